// File: rtl/rca_wb_buffer.sv
// Multi-channel writeback buffer between the RCA grid and the writeback stage.
// Per-channel result FIFOs feed one registered output stage with a round-robin grant.
module rca_wb_buffer #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned NUM_WP = 4,
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ID_W   = 3,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic [NUM_CH-1:0]               in_valid,
  output logic [NUM_CH-1:0]               in_ready,
  input  logic [NUM_CH*ID_W-1:0]          in_id,
  input  logic [NUM_CH*NUM_WP*XLEN-1:0]   in_rd,
  output logic                            done,
  output logic [ID_W-1:0]                 wb_id,
  output logic [NUM_WP*XLEN-1:0]          rd,
  output logic [CH_W-1:0]                 wb_ch,
  input  logic                            ack,
  output logic                            rca_config_locked
);

  localparam int unsigned RW = NUM_WP * XLEN;
  localparam int unsigned EW = ID_W + RW;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [EW-1:0]     mem    [NUM_CH][DEPTH];
  logic [PW-1:0]     rd_ptr [NUM_CH];
  logic [PW-1:0]     wr_ptr [NUM_CH];
  logic [CW-1:0]     count  [NUM_CH];

  logic [NUM_CH-1:0] nonempty;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [CH_W-1:0]   last_grant;
  logic [CH_W-1:0]   grant;
  logic [EW-1:0]     head;
  logic              load;

  // in_ready comes straight from the registered count: a full FIFO refuses
  // a push even in the cycle it is being popped.
  always_comb begin
    in_ready = '0;
    nonempty = '0;
    push     = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      in_ready[c] = (count[c] != CW'(DEPTH));
      nonempty[c] = (count[c] != '0);
      push[c]     = in_valid[c] && in_ready[c] && !flush;
    end
  end

  always_comb begin
    logic              found;
    logic [CH_W-1:0]   cand;
    int unsigned       idx;
    grant = last_grant;
    found = 1'b0;
    cand  = '0;
    idx   = 0;
    // Scan starts one past the last grant; the last granted channel comes last.
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      idx  = (32'(last_grant) + i) % NUM_CH;
      cand = CH_W'(idx);
      if (!found && nonempty[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    load = (!done || ack) && (|nonempty) && !flush;
    pop  = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      pop[c] = load && (grant == CH_W'(c));
    end
  end

  always_comb begin
    head = mem[grant][rd_ptr[grant]];
  end

  always_comb begin
    rca_config_locked = done || (|nonempty);
  end

  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (push[c]) begin
        mem[c][wr_ptr[c]] <= {in_id[c*ID_W +: ID_W], in_rd[c*RW +: RW]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        rd_ptr[c] <= '0;
        wr_ptr[c] <= '0;
        count[c]  <= '0;
      end
    end else if (flush) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        rd_ptr[c] <= '0;
        wr_ptr[c] <= '0;
        count[c]  <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + PW'(1);
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + PW'(1);
        count[c] <= count[c] + CW'(push[c]) - CW'(pop[c]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done       <= 1'b0;
      wb_id      <= '0;
      rd         <= '0;
      wb_ch      <= '0;
      last_grant <= CH_W'(NUM_CH - 1);
    end else if (flush) begin
      done <= 1'b0;
    end else if (load) begin
      done         <= 1'b1;
      {wb_id, rd}  <= head;
      wb_ch        <= grant;
      last_grant   <= grant;
    end else if (ack) begin
      done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rca_wb_buffer.sv
// Self-checking bench for rca_wb_buffer: directed scenarios plus a per-channel
// scoreboard that checks every consumed result against what was accepted.
module tb_rca_wb_buffer;

  localparam int NUM_CH = 2;
  localparam int NUM_WP = 4;
  localparam int XLEN   = 32;
  localparam int ID_W   = 3;
  localparam int DEPTH  = 4;
  localparam int RW     = NUM_WP * XLEN;
  localparam int EW     = ID_W + RW;

  logic                          clk = 1'b0;
  logic                          rst = 1'b0;
  logic                          flush = 1'b0;
  logic [NUM_CH-1:0]             in_valid = '0;
  logic [NUM_CH-1:0]             in_ready;
  logic [NUM_CH*ID_W-1:0]        in_id = '0;
  logic [NUM_CH*RW-1:0]          in_rd = '0;
  logic                          done;
  logic [ID_W-1:0]               wb_id;
  logic [RW-1:0]                 rd;
  logic [0:0]                    wb_ch;
  logic                          ack = 1'b0;
  logic                          rca_config_locked;

  int n_tests = 0;
  int n_fail  = 0;
  int n_cons  = 0;

  logic [EW-1:0] q0[$];
  logic [EW-1:0] q1[$];

  always #5 clk = ~clk;

  rca_wb_buffer #(
    .NUM_CH(NUM_CH), .NUM_WP(NUM_WP), .XLEN(XLEN), .ID_W(ID_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id), .in_rd(in_rd),
    .done(done), .wb_id(wb_id), .rd(rd), .wb_ch(wb_ch), .ack(ack),
    .rca_config_locked(rca_config_locked)
  );

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] mkrd(input int ch, input int id);
    logic [RW-1:0] r;
    for (int w = 0; w < NUM_WP; w++) r[w*XLEN +: XLEN] = 32'(32'h1000 * (ch + 1) + id * 8 + w);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic v, input int id, input logic [RW-1:0] data);
    in_valid[c]             = v;
    in_id[c*ID_W +: ID_W]   = ID_W'(id);
    in_rd[c*RW +: RW]       = data;
  endtask

  task automatic clear_inputs();
    in_valid = '0;
    in_id    = '0;
    in_rd    = '0;
    ack      = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    tick();
  endtask

  task automatic drain(input string tag);
    ack = 1'b1;
    for (int i = 0; i < 40 && rca_config_locked; i++) tick();
    check(tag, rca_config_locked, 1'b0);
    ack = 1'b0;
  endtask

  // Scoreboard: inputs and state seen at the negedge are what the next posedge acts on.
  always @(negedge clk) begin : sb
    logic [EW-1:0] e;
    if (!rst || flush) begin
      q0.delete();
      q1.delete();
    end else begin
      if (done && ack) begin
        n_cons++;
        if ((wb_ch == 1'b0) ? (q0.size() == 0) : (q1.size() == 0)) begin
          check("sb_underflow", 1, 0);
        end else begin
          e = (wb_ch == 1'b0) ? q0.pop_front() : q1.pop_front();
          check("sb_result", {wb_id, rd}, e);
        end
      end
      if (in_valid[0] && in_ready[0]) q0.push_back({in_id[0 +: ID_W], in_rd[0 +: RW]});
      if (in_valid[1] && in_ready[1]) q1.push_back({in_id[ID_W +: ID_W], in_rd[RW +: RW]});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [ID_W-1:0] got[8];
    logic [ID_W-1:0] exp_rr[8];
    logic [159:0]    snap;
    int n, acc;

    // Reset with random inputs
    rst      = 1'b0;
    in_valid = NUM_CH'($urandom);
    in_id    = NUM_CH*ID_W'($urandom);
    in_rd    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    ack      = 1'($urandom);
    flush    = 1'($urandom);
    #22;
    check("rst_done", done, 1'b0);
    check("rst_rd", rd, '0);
    check("rst_id_ch", {wb_id, wb_ch}, '0);
    check("rst_ready", in_ready, 2'b11);
    check("rst_locked", rca_config_locked, 1'b0);
    clear_inputs();
    @(posedge clk);
    #3 rst = 1'b1;
    tick();

    // Latency: push at cycle 0, done at cycle 2, ack clears at cycle 3
    set_ch(0, 1'b1, 5, 128'h00000004_00000003_00000002_00000001);
    tick();
    set_ch(0, 1'b0, 0, '0);
    check("lat_done_c1", done, 1'b0);
    tick();
    check("lat_done_c2", done, 1'b1);
    check("lat_id", wb_id, 3'd5);
    check("lat_ch", wb_ch, 1'b0);
    check("lat_rd", rd, 128'h00000004_00000003_00000002_00000001);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("lat_ack_clr", done, 1'b0);

    // Round-robin with ack held high
    do_reset();
    exp_rr = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd6, 3'd3, 3'd7};
    ack = 1'b1;
    n = 0;
    for (int k = 0; k < 30; k++) begin
      if (k < 4) begin
        set_ch(0, 1'b1, k, mkrd(0, k));
        set_ch(1, 1'b1, 4 + k, mkrd(1, 4 + k));
      end else begin
        in_valid = '0;
      end
      tick();
      if (done && n < 8) begin
        got[n] = wb_id;
        n++;
      end
    end
    ack = 1'b0;
    check("rr_count", n, 8);
    for (int i = 0; i < 8; i++) check("rr_seq", got[i], exp_rr[i]);
    check("rr_idle", rca_config_locked, 1'b0);

    // Backpressure: DEPTH entries plus one in the output stage
    do_reset();
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      set_ch(0, 1'b1, acc, mkrd(0, acc));
      if (in_valid[0] && in_ready[0]) acc++;
      tick();
    end
    check("bp_accepted", acc, 5);
    check("bp_ready_low", in_ready[0], 1'b0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("bp_ready_rise", in_ready[0], 1'b1);
    if (in_valid[0] && in_ready[0]) acc++;
    tick();
    set_ch(0, 1'b0, 0, '0);
    check("bp_sixth", acc, 6);
    check("bp_full_again", in_ready[0], 1'b0);
    drain("bp_drain");

    // Stability while done && !ack, then grant passes to the other channel
    do_reset();
    set_ch(0, 1'b1, 2, mkrd(0, 2));
    tick();
    set_ch(0, 1'b0, 0, '0);
    tick();
    check("stab_done", done, 1'b1);
    snap = {wb_id, rd, wb_ch};
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      set_ch(1, 1'b1, acc, mkrd(1, acc));
      if (in_valid[1] && in_ready[1]) acc++;
      tick();
      check("stab_hold", {wb_id, rd, wb_ch}, snap);
    end
    set_ch(1, 1'b0, 0, '0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("stab_next_ch", {done, wb_ch}, 2'b11);
    drain("stab_drain");

    // Flush overrides ack and a same-cycle push
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_ch(0, 1'b1, k, mkrd(0, k));
      set_ch(1, (k < 2), 4 + k, mkrd(1, 4 + k));
      tick();
    end
    in_valid = '0;
    check("fl_pre", {done, rca_config_locked}, 2'b11);
    flush = 1'b1;
    ack   = 1'b1;
    set_ch(0, 1'b1, 7, mkrd(0, 7));
    tick();
    flush = 1'b0;
    ack   = 1'b0;
    in_valid = '0;
    check("fl_done", done, 1'b0);
    check("fl_ready", in_ready, 2'b11);
    check("fl_locked", rca_config_locked, 1'b0);
    tick();
    check("fl_no_load", {done, rca_config_locked}, 2'b00);

    // Asynchronous reset mid-stream
    do_reset();
    ack = 1'b1;
    for (int k = 0; k < 6; k++) begin
      set_ch(0, 1'b1, k, mkrd(0, k));
      set_ch(1, 1'b1, k + 2, mkrd(1, k + 2));
      tick();
    end
    #2 rst = 1'b0;
    #1;
    check("ar_done", done, 1'b0);
    check("ar_out", {wb_id, rd, wb_ch}, '0);
    check("ar_ready", in_ready, 2'b11);
    check("ar_locked", rca_config_locked, 1'b0);
    clear_inputs();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("ar_no_stale", {done, rca_config_locked}, 2'b00);
    end

    check("sb_activity", (n_cons > 0), 1'b1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
